// File: rtl/branch_resolve_unit.sv
// Branch resolution back end: carries D-stage predictions through E/M, checks them in M,
// drives the predictor update bus, issues redirect/flush pulses and keeps accuracy counters.
module branch_resolve_unit #(
  parameter int unsigned FALLTHRU_OFS   = 8,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned RECOVER_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branchD,
  input  logic [31:0]       pcD,
  input  logic              predD,
  input  logic              localPredD,
  input  logic              globalPredD,
  input  logic              actual_takeE,
  input  logic [31:0]       targetE,
  input  logic              stallE,
  input  logic              stallM,
  input  logic              flushE,
  output logic              branchM,
  output logic [31:0]       pcM,
  output logic              actual_takeM,
  output logic              localPred_M,
  output logic              globalPred_M,
  output logic              mispredM,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic              flush_req,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispred_cnt,
  output logic [CNT_W-1:0]  local_ok_cnt,
  output logic [CNT_W-1:0]  global_ok_cnt
);

  localparam int unsigned PC_W = 32;
  localparam int unsigned RC_W = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {NORMAL = 1'b0, RECOVER = 1'b1} state_t;

  state_t           state;
  logic [RC_W-1:0]  rcnt;

  logic             validE, predE, localE, globalE;
  logic [PC_W-1:0]  pcE;
  logic             validM, predM;
  logic [PC_W-1:0]  targetM;
  logic             mis;

  // D->E pipeline register; a stall holds the entry even against a flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validE  <= 1'b0;
      pcE     <= '0;
      predE   <= 1'b0;
      localE  <= 1'b0;
      globalE <= 1'b0;
    end else if (!stallE) begin
      if (flushE || flush_req) begin
        validE <= 1'b0;
      end else begin
        validE  <= branchD;
        pcE     <= pcD;
        predE   <= predD;
        localE  <= localPredD;
        globalE <= globalPredD;
      end
    end
  end

  // E->M pipeline register, also latching the resolved outcome
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      validM       <= 1'b0;
      pcM          <= '0;
      predM        <= 1'b0;
      localPred_M  <= 1'b0;
      globalPred_M <= 1'b0;
      actual_takeM <= 1'b0;
      targetM      <= '0;
    end else if (!stallM) begin
      if (flush_req) begin
        validM <= 1'b0;
      end else begin
        validM       <= validE;
        pcM          <= pcE;
        predM        <= predE;
        localPred_M  <= localE;
        globalPred_M <= globalE;
        actual_takeM <= actual_takeE;
        targetM      <= targetE;
      end
    end
  end

  assign mis            = validM & (predM ^ actual_takeM);
  assign branchM        = validM & ~stallM & (state == NORMAL);
  assign mispredM       = mis & branchM;
  assign redirect_valid = mis & branchM;
  assign flush_req      = mis & branchM;
  // Gated by validM so an empty M stage presents an all-zero redirect address
  assign redirect_pc    = !validM ? '0 :
                          actual_takeM ? targetM : pcM + PC_W'(FALLTHRU_OFS);

  // Recovery window: suppress updates from wrong-path leftovers after a redirect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= NORMAL;
      rcnt  <= '0;
    end else begin
      case (state)
        NORMAL: begin
          if (flush_req && (RECOVER_CYCLES != 0)) begin
            state <= RECOVER;
            rcnt  <= RC_W'(RECOVER_CYCLES - 1);
          end
        end
        RECOVER: begin
          if (rcnt == '0) state <= NORMAL;
          else            rcnt  <= rcnt - RC_W'(1);
        end
        default: state <= NORMAL;
      endcase
    end
  end

  // Saturating accuracy statistics, advanced only on real updates
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt    <= '0;
      mispred_cnt   <= '0;
      local_ok_cnt  <= '0;
      global_ok_cnt <= '0;
    end else if (branchM) begin
      if (branch_cnt != CNT_MAX)
        branch_cnt <= branch_cnt + CNT_W'(1);
      if (mis && (mispred_cnt != CNT_MAX))
        mispred_cnt <= mispred_cnt + CNT_W'(1);
      if ((localPred_M == actual_takeM) && (local_ok_cnt != CNT_MAX))
        local_ok_cnt <= local_ok_cnt + CNT_W'(1);
      if ((globalPred_M == actual_takeM) && (global_ok_cnt != CNT_MAX))
        global_ok_cnt <= global_ok_cnt + CNT_W'(1);
    end
  end

endmodule
